// File: rtl/crc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : crc_pkg
// Purpose  : Shared constants and FSM state encoding for the serial CRC checker.
// Revision : 1.0 - initial release
// ============================================================================
package crc_pkg;

    localparam int CRC_DATA_W = 8;
    localparam int CRC_W      = 4;
    localparam logic [CRC_W-1:0] CRC_POLY = 4'h3;
    localparam int CRC_CW_W   = CRC_DATA_W + CRC_W;

    typedef enum logic [1:0] {
        SHIFT = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/crc_serial_step.sv
`default_nettype none
// ============================================================================
// Module   : crc_serial_step
// Purpose  : One MSB-first polynomial division step (one codeword bit in).
// Revision : 1.0 - initial release
// ============================================================================
module crc_serial_step #(
    parameter int CRC_W = crc_pkg::CRC_W
) (
    input  logic [CRC_W-1:0] rem_in,
    input  logic             bit_in,
    input  logic [CRC_W-1:0] poly,
    output logic [CRC_W-1:0] rem_out
);
    import crc_pkg::*;

    logic w_fb;

    // The bit leaving the top of the remainder decides whether to subtract G.
    assign w_fb    = rem_in[CRC_W-1];
    assign rem_out = {rem_in[CRC_W-2:0], bit_in} ^ (w_fb ? poly : {CRC_W{1'b0}});

endmodule
`default_nettype wire

// File: rtl/crc_validator.sv
`default_nettype none
// ============================================================================
// Module   : crc_validator
// Purpose  : Serial checker for one DATA_W+CRC_W codeword, restarted by rst.
//            Define CRC_VALIDATOR_REMAINDER_EN to expose the remainder port.
// Revision : 1.0 - initial release
// ============================================================================
module crc_validator #(
    parameter int DATA_W = crc_pkg::CRC_DATA_W,
    parameter int CRC_W  = crc_pkg::CRC_W,
    parameter logic [CRC_W-1:0] POLY = crc_pkg::CRC_POLY
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_W+CRC_W-1:0]   data_in,
`ifdef CRC_VALIDATOR_REMAINDER_EN
    output logic [CRC_W-1:0]          remainder,
`endif
    output logic                      valid,
    output logic                      done
);
    import crc_pkg::*;

    localparam int c_cw_w  = DATA_W + CRC_W;
    localparam int c_cnt_w = $clog2(c_cw_w + 1);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_cw_w - 1);

    state_t              r_state;
    logic [c_cw_w-1:0]   r_shift;
    logic [CRC_W-1:0]    r_rem;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                r_done;
    logic                r_valid;
    logic [CRC_W-1:0]    w_rem_next;

    crc_serial_step #(
        .CRC_W   (CRC_W)
    ) u_step (
        .rem_in  (r_rem),
        .bit_in  (r_shift[c_cw_w-1]),
        .poly    (POLY),
        .rem_out (w_rem_next)
    );

    // rst doubles as the load strobe, so data_in is only sampled here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= data_in;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_state <= SHIFT;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                SHIFT: begin
                    r_shift <= r_shift << 1;
                    r_rem   <= w_rem_next;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == c_last) begin
                        r_state <= CHECK;
                    end
                end
                CHECK: begin
                    r_done  <= 1'b1;
                    r_valid <= (r_rem == '0);
                    r_state <= DONE;
                end
                DONE: begin
                    r_state <= DONE;
                end
                default: begin
                    r_state <= DONE;
                end
            endcase
        end
    end

    assign valid = r_valid;
    assign done  = r_done;

`ifdef CRC_VALIDATOR_REMAINDER_EN
    assign remainder = r_rem;
`endif

endmodule
`default_nettype wire

// File: tb/tb_crc_validator.sv
`default_nettype none
// ============================================================================
// Module   : tb_crc_validator
// Purpose  : Scoreboard bench for crc_validator (x^4+x+1, 12-bit codeword).
// Revision : 1.0 - initial release
// ============================================================================
module tb_crc_validator;

    logic        clk;
    logic        rst;
    logic [11:0] data_in;
    logic        valid;
    logic        done;
`ifdef CRC_VALIDATOR_REMAINDER_EN
    logic [3:0]  remainder;
`endif

    int n_total;
    int n_bad;

    // Expected {valid, remainder} per started word.
    logic [4:0] sb[$];

    crc_validator dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
`ifdef CRC_VALIDATOR_REMAINDER_EN
        .remainder (remainder),
`endif
        .valid     (valid),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Remainder by long division over the full 12-bit word.
    function automatic logic [3:0] mod_g(input logic [11:0] cw);
        logic [11:0] w;
        logic [11:0] g;
        w = cw;
        for (int i = 11; i >= 4; i--) begin
            if (w[i]) begin
                g = 12'h013 << (i - 4);
                w = w ^ g;
            end
        end
        return w[3:0];
    endfunction

    task automatic check_result(input logic [11:0] cw);
        logic [4:0] exp;
        if (sb.size() == 0) begin
            n_total++;
            n_bad++;
            $display("FAIL scoreboard_empty cw=%h", cw);
        end else begin
            exp = sb.pop_front();
            n_total++;
            if (valid !== exp[4]) begin
                n_bad++;
                $display("FAIL valid cw=%h got=%b want=%b", cw, valid, exp[4]);
            end
`ifdef CRC_VALIDATOR_REMAINDER_EN
            n_total++;
            if (remainder !== exp[3:0]) begin
                n_bad++;
                $display("FAIL remainder cw=%h got=%h want=%h", cw, remainder, exp[3:0]);
            end
`endif
        end
    endtask

    // Pulse rst for `hold` edges (only the last edge carries cw), then wait for done.
    task automatic run_word(input logic [11:0] cw, input int hold,
                            input logic exp_valid, input logic [3:0] exp_rem);
        int n;
        @(negedge clk);
        rst = 1'b1;
        for (int h = 0; h < hold; h++) begin
            data_in = (h == hold - 1) ? cw : ~cw;
            @(negedge clk);
        end
        rst = 1'b0;
        data_in = $urandom_range(0, 4095);
        sb.push_back({exp_valid, exp_rem});
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            data_in = $urandom_range(0, 4095);
            n++;
        end
        n_total++;
        if (n != 13) begin
            n_bad++;
            $display("FAIL latency cw=%h got=%0d want=13", cw, n);
        end
        check_result(cw);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            data_in = $urandom_range(0, 4095);
            @(negedge clk);
            n_total++;
            if (done !== 1'b0 || valid !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_outputs done=%b valid=%b want 0/0", done, valid);
            end
`ifdef CRC_VALIDATOR_REMAINDER_EN
            n_total++;
            if (remainder !== 4'h0) begin
                n_bad++;
                $display("FAIL reset_remainder got=%h want=0", remainder);
            end
`endif
        end
    endtask

    task automatic test_known_vectors();
        run_word(12'hCCE, 2, 1'b1, 4'h0);
        run_word(12'hAA8, 1, 1'b0, 4'h1);
        run_word(12'h000, 1, 1'b1, 4'h0);
        run_word(12'h001, 1, 1'b0, 4'h1);
    endtask

    task automatic test_abort();
        int n;
        @(negedge clk);
        rst = 1'b1;
        data_in = 12'hAA8;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        // Edge 6 sees rst again with a different word.
        rst = 1'b1;
        data_in = 12'hCCE;
        @(negedge clk);
        rst = 1'b0;
        data_in = 12'hAA8;
        sb.push_back({1'b1, 4'h0});
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_total++;
        if (n != 13) begin
            n_bad++;
            $display("FAIL abort_latency got=%0d want=13", n);
        end
        check_result(12'hCCE);
    endtask

    task automatic test_hold_done();
        run_word(12'hCCE, 1, 1'b1, 4'h0);
        data_in = 12'hAA8;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            n_total++;
            if (done !== 1'b1 || valid !== 1'b1) begin
                n_bad++;
                $display("FAIL hold_done k=%0d done=%b valid=%b want 1/1", k, done, valid);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        n_total++;
        if (done !== 1'b0 || valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_after_done done=%b valid=%b want 0/0", done, valid);
        end
        rst = 1'b0;
    endtask

    task automatic test_sweep();
        logic [3:0]  crc;
        logic [3:0]  flip;
        logic [11:0] cw;
        for (int d = 0; d < 256; d++) begin
            cw  = {d[7:0], 4'h0};
            crc = mod_g(cw);
            cw  = {d[7:0], crc};
            run_word(cw, 1, 1'b1, 4'h0);
            flip = 4'h1 << (d % 4);
            // A single low-order error term is smaller than G, so it is its own remainder.
            run_word({d[7:0], crc ^ flip}, 1, 1'b0, flip);
        end
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst     = 1'b1;
        data_in = '0;
        test_reset();
        test_known_vectors();
        test_abort();
        test_hold_done();
        test_sweep();
        n_total++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule
`default_nettype wire
